// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of 2**SEL_W requesters a registered select/enable pair for a 4-to-16 decoder.
// Optional macro ARB_TIMEOUT_EN bounds each ownership to MAX_HOLD grant cycles.
module decoder_rr_arbiter #(
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_arb_en,
    input  logic [(1<<SEL_W)-1:0] i_req,
    output logic [SEL_W-1:0]      o_select,
    output logic                  o_enable,
    output logic [(1<<SEL_W)-1:0] o_grant,
    output logic                  o_busy
);
    localparam int N = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_select;
    logic             r_enable;
    logic [N-1:0]     r_grant;

    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_winner;
    logic             w_any;
    logic             w_timeout;
    logic             w_leave;

    // Descending scan so the lowest offset from r_ptr is written last and wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = r_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold;

    // r_hold counts completed grant cycles; the MAX_HOLD-th cycle is the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_hold <= '0;
        else if (r_state != GRANT)
            r_hold <= '0;
        else
            r_hold <= r_hold + 1'b1;
    end

    assign w_timeout = (r_hold == HW'(MAX_HOLD - 1));
`else
    // Owner holds indefinitely; MAX_HOLD only matters with the timeout build.
    assign w_timeout = (MAX_HOLD < 0);
`endif

    assign w_leave = !i_req[r_select] || !i_arb_en || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_arb_en && w_any) w_state_nxt = GRANT;
            GRANT:   if (w_leave)           w_state_nxt = GAP;
            GAP:                            w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_select <= '0;
            r_enable <= 1'b0;
            r_grant  <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_arb_en && w_any) begin
                        r_select <= w_winner;
                        r_enable <= 1'b1;
                        r_grant  <= {{(N-1){1'b0}}, 1'b1} << w_winner;
                    end
                end
                GRANT: begin
                    if (w_leave) begin
                        r_enable <= 1'b0;
                        r_grant  <= '0;
                        r_ptr    <= r_select + 1'b1;
                    end
                end
                default: begin
                    r_enable <= 1'b0;
                    r_grant  <= '0;
                end
            endcase
        end
    end

    assign o_select = r_select;
    assign o_enable = r_enable;
    assign o_grant  = r_grant;
    assign o_busy   = (r_state != IDLE);

endmodule
